// File: rtl/mem_wb_stage_pkg.sv
// Shared writeback-control encodings, stage state type and alignment helper.
package mem_wb_stage_pkg;

    // Writeback source select
    localparam logic [2:0] WB_ALU    = 3'd0;
    localparam logic [2:0] WB_PCADD4 = 3'd1;
    localparam logic [2:0] WB_DMEM   = 3'd2;

    // Load access size
    localparam logic [1:0] DMEM_EXT_BYTE = 2'd0;
    localparam logic [1:0] DMEM_EXT_HALF = 2'd1;
    localparam logic [1:0] DMEM_EXT_WORD = 2'd2;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    // A halfword needs an even offset; a word (or any wider code) needs offset 0.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            DMEM_EXT_BYTE: return 1'b0;
            DMEM_EXT_HALF: return off[0];
            default:       return off != 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/mem_wb_stage_load_extend.sv
// Combinational load alignment and sign/zero extension of a raw dmem word.
module load_extend
    import mem_wb_stage_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      offset,
    input  logic [1:0]      size,
    input  logic            unsign,
    output logic [XLEN-1:0] data,
    output logic            misaligned
);

    logic [7:0]  byte_val;
    logic [15:0] half_val;

    // Pick the addressed byte/halfword and extend it to XLEN
    always_comb begin
        byte_val   = rdata[8*offset +: 8];
        half_val   = rdata[16*offset[1] +: 16];
        misaligned = is_misaligned(size, offset);
        case (size)
            DMEM_EXT_BYTE: data = {{(XLEN-8){~unsign & byte_val[7]}}, byte_val};
            DMEM_EXT_HALF: data = {{(XLEN-16){~unsign & half_val[15]}}, half_val};
            default:       data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// Final pipeline stage: selects the writeback source, aligns/extends loads,
// stalls upstream while a load waits on dmem, and flags timeout/misalignment.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned LOAD_TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      in_rd,
    input  logic            in_rd_we,
    input  logic [2:0]      in_wb_sel,
    input  logic            in_ext_unsign,
    input  logic [1:0]      in_ext_size,
    input  logic [XLEN-1:0] in_alu_result,
    input  logic [XLEN-1:0] in_pc_add4,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            load_busy,
    output logic            misalign_err,
    output logic            timeout_err
);

    localparam int unsigned CW = (LOAD_TIMEOUT > 0) ? $clog2(LOAD_TIMEOUT + 1) : 1;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    // Fields of the instruction whose load is outstanding
    logic [4:0]      hold_rd;
    logic            hold_we;
    logic            hold_unsign;
    logic [1:0]      hold_size;
    logic [1:0]      hold_off;

    // One-entry skid for a register-source write that collides with a load result
    logic            pend_vld_q, pend_vld_d;
    logic            pend_we_q, pend_we_d;
    logic [4:0]      pend_addr_q, pend_addr_d;
    logic [XLEN-1:0] pend_data_q, pend_data_d;

    logic            accept, is_load, is_reg, acc_load, acc_mis, acc_reg;
    logic            load_done, timeout;
    logic            new_we;
    logic [XLEN-1:0] new_data;
    logic [XLEN-1:0] ext_data;
    logic            ext_misaligned;
    logic            out_upd, out_we;
    logic [4:0]      out_addr;
    logic [XLEN-1:0] out_data;

    load_extend #(.XLEN(XLEN)) u_load_extend (
        .rdata      (dmem_rdata),
        .offset     (hold_off),
        .size       (hold_size),
        .unsign     (hold_unsign),
        .data       (ext_data),
        .misaligned (ext_misaligned)
    );

    // Handshake, next-state, timeout counter and write-port arbitration
    always_comb begin
        in_ready  = (state_q == ST_IDLE) | ((state_q == ST_WAIT) & dmem_rvalid);
        load_busy = (state_q == ST_WAIT);
        accept    = in_valid & in_ready;
        is_load   = (in_wb_sel == WB_DMEM);
        is_reg    = (in_wb_sel == WB_ALU) | (in_wb_sel == WB_PCADD4);
        acc_mis   = accept & is_load & is_misaligned(in_ext_size, in_alu_result[1:0]);
        acc_load  = accept & is_load & ~acc_mis;
        acc_reg   = accept & is_reg;
        load_done = (state_q == ST_WAIT) & dmem_rvalid;
        timeout   = (LOAD_TIMEOUT != 0) & (state_q == ST_WAIT) & ~dmem_rvalid
                    & ((cnt_q + 1'b1) == CW'(LOAD_TIMEOUT));
        new_we    = in_rd_we & (in_rd != 5'd0);
        new_data  = (in_wb_sel == WB_PCADD4) ? in_pc_add4 : in_alu_result;

        state_d = state_q;
        if (acc_load)       state_d = ST_WAIT;
        else if (load_done) state_d = ST_IDLE;
        else if (timeout)   state_d = ST_IDLE;

        cnt_d = cnt_q;
        if (acc_load)
            cnt_d = '0;
        else if ((LOAD_TIMEOUT != 0) & (state_q == ST_WAIT) & ~dmem_rvalid)
            cnt_d = cnt_q + 1'b1;

        out_upd     = 1'b0;
        out_we      = 1'b0;
        out_addr    = rf_waddr;
        out_data    = rf_wdata;
        pend_vld_d  = pend_vld_q;
        pend_we_d   = pend_we_q;
        pend_addr_d = pend_addr_q;
        pend_data_d = pend_data_q;

        // A load result and a same-cycle ALU/link accept both target the next
        // edge; the load wins and the other write slips one cycle into the
        // skid, which drains on the first cycle without a new ALU/link accept.
        if (load_done) begin
            out_upd  = 1'b1;
            out_we   = hold_we;
            out_addr = hold_rd;
            out_data = ext_data;
            if (acc_reg) begin
                pend_vld_d  = 1'b1;
                pend_we_d   = new_we;
                pend_addr_d = in_rd;
                pend_data_d = new_data;
            end
        end else if (pend_vld_q) begin
            out_upd  = 1'b1;
            out_we   = pend_we_q;
            out_addr = pend_addr_q;
            out_data = pend_data_q;
            if (acc_reg) begin
                pend_we_d   = new_we;
                pend_addr_d = in_rd;
                pend_data_d = new_data;
            end else begin
                pend_vld_d = 1'b0;
            end
        end else if (acc_reg) begin
            out_upd  = 1'b1;
            out_we   = new_we;
            out_addr = in_rd;
            out_data = new_data;
        end
    end

    // State, counter, skid and error flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            pend_vld_q   <= 1'b0;
            pend_we_q    <= 1'b0;
            pend_addr_q  <= '0;
            pend_data_q  <= '0;
            misalign_err <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pend_vld_q   <= pend_vld_d;
            pend_we_q    <= pend_we_d;
            pend_addr_q  <= pend_addr_d;
            pend_data_q  <= pend_data_d;
            misalign_err <= acc_mis;
            timeout_err  <= timeout_err | timeout;
        end
    end

    // Holding register captured on every accepted instruction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_rd     <= '0;
            hold_we     <= 1'b0;
            hold_unsign <= 1'b0;
            hold_size   <= '0;
            hold_off    <= '0;
        end else if (accept) begin
            hold_rd     <= in_rd;
            hold_we     <= new_we;
            hold_unsign <= in_ext_unsign;
            hold_size   <= in_ext_size;
            hold_off    <= in_alu_result[1:0];
        end
    end

    // Registered register-file write port; address/data hold when idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we <= out_we;
            if (out_upd) begin
                rf_waddr <= out_addr;
                rf_wdata <= out_data;
            end
        end
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Final pipeline stage of the core. Consumes the writeback controls from the writeback decoder (wb_sel, dmem_ext_unsign, dmem_ext_size), the ALU result, PC+4 and the data-memory load response.
- Performs load alignment and extension, selects the writeback source, and drives registered register-file write signals.
- Stalls upstream with a valid/ready handshake while a load waits for a variable-latency dmem response.
- Detects load timeout and misaligned accesses.

Parameters:
- XLEN, 32, datapath width.
- LOAD_TIMEOUT, 255, maximum cycles spent in WAIT before timeout is declared; 0 disables the timeout. The counter width is $clog2(LOAD_TIMEOUT+1).

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream holds a valid instruction.
- in_ready  out  1  stage can accept.
- in_rd  in  5  destination register.
- in_rd_we  in  1  instruction writes rd.
- in_wb_sel  in  3  writeback source (WB_ALU / WB_PCADD4 / WB_DMEM).
- in_ext_unsign  in  1  zero-extend load.
- in_ext_size  in  2  DMEM_EXT_BYTE / HALF / WORD.
- in_alu_result  in  XLEN  ALU result; bits [1:0] give the load byte offset.
- in_pc_add4  in  XLEN  link value.
- dmem_rvalid  in  1  load data valid this cycle.
- dmem_rdata  in  XLEN  raw aligned word.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  5  write address.
- rf_wdata  out  XLEN  write data.
- load_busy  out  1  high in WAIT, used by hazard logic.
- misalign_err  out  1  one-cycle pulse.
- timeout_err  out  1  sticky until reset.

Behaviour:
- Reset (async on rst_n low): state IDLE, rf_we 0, rf_waddr 0, rf_wdata 0, misalign_err 0, timeout_err 0, counter 0. load_busy 0 and in_ready 1 follow combinationally from IDLE.
- States: IDLE, WAIT.
- in_ready = (state==IDLE) | (state==WAIT & dmem_rvalid).
- Accept = in_valid & in_ready. On accept, rd, rd_we, wb_sel, ext fields, offset and pc_add4 are captured into an internal holding register.
- Non-load accept (wb_sel WB_ALU or WB_PCADD4):
  - Next edge: rf_we = in_rd_we & (in_rd!=0), rf_waddr = in_rd, rf_wdata = selected source. Latency 1.
  - State stays IDLE.
- Load accept (wb_sel WB_DMEM): state goes to WAIT, counter clears, rf_we 0 next cycle.
- In WAIT with dmem_rvalid: the extracted data from the held fields is registered, so rf_we pulses the following cycle (rd!=0 and rd_we required). State returns to IDLE unless a new instruction is accepted the same cycle; that instruction is handled per the accept rules, so back-to-back loads are allowed with no bubble.
- dmem_rvalid outside WAIT is ignored.
- Extraction, where off = captured offset:
  - BYTE: byte = rdata[8*off +: 8].
  - HALF: rdata[16*off[1] +: 16].
  - WORD: whole word.
  - Sign-extend unless unsign.
- Misaligned access: HALF with off[0]=1, or WORD with off!=0.
  - Detected at accept. No WAIT entry, rf_we 0, misalign_err pulses 1 cycle after accept.
  - The store/load request is still issued by upstream; the stage simply discards the response.
- Unknown wb_sel (any encoding outside the three): rf_we 0, no error, stay IDLE.
- Timeout: the counter increments each WAIT cycle without rvalid. On reaching LOAD_TIMEOUT (nonzero), set timeout_err (sticky), return to IDLE, no write. A late rvalid is then ignored.
- rf_wdata is a don't-care when rf_we is 0, but holds its last value (no X).
- Reset mid-WAIT drops the pending load; no write follows.

Decomposition:
- WB_* and DMEM_EXT_* encodings live in CtrlCode.vh; OPC_*/FNC_* stay in OpCode.vh. Reuse them here; no new literals.
- State encoding is a localparam in this module.
- Natural sub-module: load_extend (combinational: rdata, offset, size, unsign -> extended data, misaligned flag), reusable by a future LSU.

Test Plan:
- ALU op: accept wb_sel=WB_ALU, rd=5, alu=0x0000_1234 -> next cycle rf_we=1, waddr=5, wdata=0x0000_1234; in_ready stays 1.
- JAL link: wb_sel=WB_PCADD4, rd=1, pc_add4=0x0000_0104 -> wdata=0x0000_0104. Same with rd=0 -> rf_we=0.
- LB / LBU, off=3: rdata=0x80AA_BBCC, rvalid after 4 cycles.
  - load_busy=1 and in_ready=0 for those cycles.
  - LB writes 0xFFFF_FF80; LBU writes 0x0000_0080, one cycle after rvalid.
- LH, off=2, rdata=0x7FFF_0000 -> 0x0000_7FFF. LH off=1 -> misalign_err pulse, rf_we=0, no WAIT.
- Back-to-back: rvalid for load A coincides with accept of load B -> A written next cycle, B in WAIT, then B written; no lost or duplicated writes.
- Timeout with LOAD_TIMEOUT=8: no rvalid.
  - After 8 WAIT cycles timeout_err=1 and stays 1; state IDLE; rf_we never asserted; a later rvalid is ignored.
  - Assert rst_n low mid-WAIT -> all outputs reset immediately.
